button_input_port: RTL and testbench

- Memory-mapped input peripheral that brings the SOC's BUTTONS pins into the CPU's IO space. It is the input-direction counterpart of the LED output path.
- Per button: two-flop synchronizer, counter-based debouncer, and sticky press/release event flags.
- The CPU reads levels and events over the SOC IO bus and clears events with write-1-to-clear.

---
 rtl/button_input_port.sv | 137 +++++++++++++
 tb/tb_button_input_port.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_input_port.sv
// button_input_port: synchronizes and debounces button pins, keeps sticky press/release flags readable on the SOC IO bus.
// Latency: a clean pin change lands in STATE 2+DEBOUNCE_CYCLES edges after it is first sampled; io_rdata is valid one cycle after io_rstrb.
// Backpressure: none; every selected single-cycle strobe is accepted. Define BUTTON_IRQ_EN for IRQ_MASK at offset 3 and an irq output.
module button_input_port #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_BUTTONS-1:0] BUTTONS,
  input  logic                   io_sel,
  input  logic [1:0]             io_addr,
  input  logic                   io_rstrb,
  input  logic                   io_wstrb,
  input  logic [31:0]            io_wdata,
  output logic [31:0]            io_rdata
`ifdef BUTTON_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_STATE    = 2'd0;
  localparam logic [1:0] ADDR_PRESSED  = 2'd1;
  localparam logic [1:0] ADDR_RELEASED = 2'd2;
`ifdef BUTTON_IRQ_EN
  localparam logic [1:0] ADDR_MASK     = 2'd3;
`endif

  logic [NUM_BUTTONS-1:0] s1, s2, stable;
  logic [NUM_BUTTONS-1:0] pressed, released;
  logic [CW-1:0]          cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] accept, rise, fall;
  logic [NUM_BUTTONS-1:0] clr_pressed, clr_released;
  logic                   wr_en, rd_en;
  logic [31:0]            rd_word;

  // Upper write-data bits have no register behind them when NUM_BUTTONS < 32.
  logic                   unused_wdata;
  assign unused_wdata = ^io_wdata;

`ifdef BUTTON_IRQ_EN
  logic [NUM_BUTTONS-1:0] irq_mask;
`endif

  assign wr_en = io_sel & io_wstrb;
  assign rd_en = io_sel & io_rstrb;

  // A bit is accepted once s2 has differed from stable for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
    rise = accept & s2;
    fall = accept & ~s2;
  end

  // W1C masks; a simultaneous hardware set still wins because it is OR-ed in after the clear.
  always_comb begin
    clr_pressed  = '0;
    clr_released = '0;
    if (wr_en && io_addr == ADDR_PRESSED)  clr_pressed  = io_wdata[NUM_BUTTONS-1:0];
    if (wr_en && io_addr == ADDR_RELEASED) clr_released = io_wdata[NUM_BUTTONS-1:0];
  end

  // Synchronizer, per-bit debounce counters and the accepted stable level.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      s1 <= BUTTONS;
      s2 <= s1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        // Matching the stable level (a glitch back) or accepting both restart the count.
        if (s2[i] == stable[i] || accept[i]) cnt[i] <= '0;
        else                                 cnt[i] <= cnt[i] + CW'(1);
      end
      stable <= stable ^ accept;
    end
  end

  // Sticky event flags, set on the same edge stable changes.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pressed  <= '0;
      released <= '0;
    end else begin
      pressed  <= (pressed  & ~clr_pressed)  | rise;
      released <= (released & ~clr_released) | fall;
    end
  end

`ifdef BUTTON_IRQ_EN
  // Interrupt mask register and registered interrupt from the current flag state.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && io_addr == ADDR_MASK) irq_mask <= io_wdata[NUM_BUTTONS-1:0];
      irq <= |((pressed | released) & irq_mask);
    end
  end
`endif

  // Register-map read mux; unused bits and offsets read as zero.
  always_comb begin
    rd_word = '0;
    case (io_addr)
      ADDR_STATE:    rd_word[NUM_BUTTONS-1:0] = stable;
      ADDR_PRESSED:  rd_word[NUM_BUTTONS-1:0] = pressed;
      ADDR_RELEASED: rd_word[NUM_BUTTONS-1:0] = released;
      default: begin
`ifdef BUTTON_IRQ_EN
        rd_word[NUM_BUTTONS-1:0] = irq_mask;
`else
        rd_word = '0;
`endif
      end
    endcase
  end

  // Registered read data, zero in any cycle that does not follow a selected read.
  always_ff @(posedge CLK) begin
    if (!RESET)     io_rdata <= '0;
    else if (rd_en) io_rdata <= rd_word;
    else            io_rdata <= '0;
  end

endmodule

// File: tb/tb_button_input_port.sv
// tb_button_input_port: scenario tasks for button_input_port with a read-expectation queue.
// Runs with NUM_BUTTONS=3, DEBOUNCE_CYCLES=4; BUTTON_IRQ_EN enables the irq scenario.
// Inputs change 1 time unit after the rising edge or on the falling edge; outputs are sampled on the falling edge.
module tb_button_input_port;

  localparam int NB = 3;
  localparam int DB = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [NB-1:0] BUTTONS = '0;
  logic          io_sel = 1'b0;
  logic [1:0]    io_addr = '0;
  logic          io_rstrb = 1'b0;
  logic          io_wstrb = 1'b0;
  logic [31:0]   io_wdata = '0;
  logic [31:0]   io_rdata;
`ifdef BUTTON_IRQ_EN
  logic          irq;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  button_input_port #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BUTTONS(BUTTONS),
    .io_sel(io_sel),
    .io_addr(io_addr),
    .io_rstrb(io_rstrb),
    .io_wstrb(io_wstrb),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata)
`ifdef BUTTON_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue one selected read and queue the value it must return; ends on the falling edge after capture.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    io_sel = 1'b1; io_addr = a; io_rstrb = 1'b1;
    exp_q.push_back(exp);
    tick();
    io_sel = 1'b0; io_rstrb = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_sel = 1'b1; io_addr = a; io_wstrb = 1'b1; io_wdata = d;
    tick();
    io_sel = 1'b0; io_wstrb = 1'b0; io_wdata = '0;
  endtask

  // Reset clears everything; a button held through reset debounces in afterwards.
  task automatic test_reset();
    RESET = 1'b0;
    BUTTONS = 3'b111;
    repeat (2) tick();
    checks++;
    if (io_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: io_rdata=%h expected 0", io_rdata); end
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), 32'h0);
      e = exp_q.pop_front(); checks++;
      if (io_rdata !== e) begin errors++; $display("FAIL reset_read a=%0d: io_rdata=%h expected %h", a, io_rdata, e); end
    end
    RESET = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      rd(2'd0, (k == 7) ? 32'h7 : 32'h0);
      e = exp_q.pop_front(); checks++;
      if (io_rdata !== e) begin errors++; $display("FAIL held_state edge=%0d: io_rdata=%h expected %h", k, io_rdata, e); end
    end
    rd(2'd1, 32'h7);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL held_pressed: io_rdata=%h expected %h", io_rdata, e); end
    BUTTONS = '0;
    repeat (10) tick();
    rd(2'd2, 32'h7);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL held_released: io_rdata=%h expected %h", io_rdata, e); end
    wr(2'd1, 32'hffff_ffff);
    wr(2'd2, 32'hffff_ffff);
  endtask

  // Clean press of button 0: STATE changes on the sixth edge after the sampling edge.
  task automatic test_debounce();
    tick();
    BUTTONS = 3'b001;
    tick();
    for (int k = 1; k <= 6; k++) begin
      rd(2'd0, (k == 6) ? 32'h1 : 32'h0);
      e = exp_q.pop_front(); checks++;
      if (io_rdata !== e) begin errors++; $display("FAIL debounce_state edge=%0d: io_rdata=%h expected %h", k, io_rdata, e); end
    end
    rd(2'd1, 32'h1);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL debounce_pressed: io_rdata=%h expected %h", io_rdata, e); end
  endtask

  // W1C clear, then a hardware set landing on the same edge as a clear.
  task automatic test_w1c();
    wr(2'd1, 32'h1);
    @(negedge CLK);
    checks++;
    if (io_rdata !== 32'h0) begin errors++; $display("FAIL nonread_rdata: io_rdata=%h expected 0", io_rdata); end
    rd(2'd1, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL w1c_pressed: io_rdata=%h expected %h", io_rdata, e); end
    tick();
    BUTTONS = 3'b000;
    repeat (10) tick();
    BUTTONS = 3'b001;
    repeat (5) tick();
    io_sel = 1'b1; io_addr = 2'd1; io_wstrb = 1'b1; io_wdata = 32'h1;
    tick();
    io_sel = 1'b0; io_wstrb = 1'b0; io_wdata = '0;
    rd(2'd1, 32'h1);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL set_wins_clear: io_rdata=%h expected %h", io_rdata, e); end
    // Read and write in the same cycle return the pre-write value.
    io_sel = 1'b1; io_addr = 2'd1; io_rstrb = 1'b1; io_wstrb = 1'b1; io_wdata = 32'h1;
    exp_q.push_back(32'h1);
    tick();
    io_sel = 1'b0; io_rstrb = 1'b0; io_wstrb = 1'b0; io_wdata = '0;
    @(negedge CLK);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL rw_same_cycle: io_rdata=%h expected %h", io_rdata, e); end
    rd(2'd1, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL rw_after_clear: io_rdata=%h expected %h", io_rdata, e); end
  endtask

  // Repeated three-cycle pulses never reach acceptance.
  task automatic test_glitch();
    tick();
    BUTTONS = 3'b000;
    repeat (10) tick();
    wr(2'd1, 32'h7);
    wr(2'd2, 32'h7);
    repeat (3) begin
      BUTTONS = 3'b001;
      repeat (3) tick();
      BUTTONS = 3'b000;
      tick();
    end
    repeat (8) tick();
    rd(2'd0, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL glitch_state: io_rdata=%h expected %h", io_rdata, e); end
    rd(2'd1, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL glitch_pressed: io_rdata=%h expected %h", io_rdata, e); end
  endtask

  // Press and release button 2, reserved offset, unselected strobes.
  task automatic test_release();
    tick();
    BUTTONS = 3'b100;
    repeat (10) tick();
    rd(2'd0, 32'h4);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL b2_state_high: io_rdata=%h expected %h", io_rdata, e); end
    BUTTONS = 3'b000;
    repeat (10) tick();
    rd(2'd2, 32'h4);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL b2_released: io_rdata=%h expected %h", io_rdata, e); end
    @(negedge CLK);
    checks++;
    if (io_rdata !== 32'h0) begin errors++; $display("FAIL rdata_after_nonread: io_rdata=%h expected 0", io_rdata); end
    rd(2'd0, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL b2_state_low: io_rdata=%h expected %h", io_rdata, e); end
    rd(2'd1, 32'h4);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL b2_pressed: io_rdata=%h expected %h", io_rdata, e); end
    rd(2'd3, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL offset3_reset: io_rdata=%h expected %h", io_rdata, e); end
`ifndef BUTTON_IRQ_EN
    wr(2'd3, 32'hffff_ffff);
    rd(2'd3, 32'h0);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL reserved_write: io_rdata=%h expected %h", io_rdata, e); end
`endif
    // Strobes without io_sel do nothing.
    io_sel = 1'b0; io_addr = 2'd2; io_rstrb = 1'b1; io_wstrb = 1'b1; io_wdata = 32'hffff_ffff;
    tick();
    io_rstrb = 1'b0; io_wstrb = 1'b0; io_wdata = '0;
    @(negedge CLK);
    checks++;
    if (io_rdata !== 32'h0) begin errors++; $display("FAIL unsel_read: io_rdata=%h expected 0", io_rdata); end
    rd(2'd2, 32'h4);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL unsel_write: io_rdata=%h expected %h", io_rdata, e); end
  endtask

`ifdef BUTTON_IRQ_EN
  // Only masked flags raise irq; clearing the last one drops irq a cycle later.
  task automatic test_irq();
    tick();
    wr(2'd1, 32'h7);
    wr(2'd2, 32'h7);
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h2);
    e = exp_q.pop_front(); checks++;
    if (io_rdata !== e) begin errors++; $display("FAIL irq_mask_read: io_rdata=%h expected %h", io_rdata, e); end
    tick();
    BUTTONS = 3'b001;
    repeat (10) tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked: irq=%b expected 0", irq); end
    BUTTONS = 3'b011;
    repeat (10) tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_masked: irq=%b expected 1", irq); end
    wr(2'd1, 32'h2);
    @(negedge CLK);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_same_cycle: irq=%b expected 1", irq); end
    @(negedge CLK);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: irq=%b expected 0", irq); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_debounce();
    test_w1c();
    test_glitch();
    test_release();
`ifdef BUTTON_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
